// File: rtl/memory_arbiter.sv
// Four-port round-robin arbiter in front of memory_controller. It holds a grant until the
// controller's ready, a request drop or the watchdog ends it, then forces one idle cycle.
module memory_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       read0,
  input  logic       read1,
  input  logic       read2,
  input  logic       read3,
  input  logic       write0,
  input  logic       write1,
  input  logic       write2,
  input  logic       write3,
  input  logic       mem_ready,
  output logic [1:0] state,
  output logic       en,
  output logic       ack0,
  output logic       ack1,
  output logic       ack2,
  output logic       ack3,
  output logic       timeout
);

  typedef enum logic [1:0] {StIdle, StBusy, StRelease} fsm_e;

  localparam logic [7:0] TLast = 8'(TIMEOUT - 1);

  fsm_e       fsm_q, fsm_d;
  logic [1:0] state_q, state_d;
  logic       en_q, en_d;
  logic [3:0] ack_q, ack_d;
  logic       timeout_q, timeout_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] tcnt_q, tcnt_d;

  logic [3:0] req;
  logic       win_valid;
  logic [1:0] win_idx;
  logic [1:0] scan_idx;
  logic       grant_req;
  logic       tlast;

  // Both lines high or both low is not a request.
  assign req = {read3 ^ write3, read2 ^ write2, read1 ^ write1, read0 ^ write0};

  assign grant_req = req[state_q];
  assign tlast     = (tcnt_q == TLast);

  // First requester found scanning upward from the priority pointer.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = ptr_q;
    scan_idx  = ptr_q;
    for (int i = 0; i < 4; i++) begin
      scan_idx = ptr_q + 2'(i);
      if (!win_valid && req[scan_idx]) begin
        win_valid = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q     <= StIdle;
      state_q   <= 2'd0;
      en_q      <= 1'b0;
      ack_q     <= 4'd0;
      timeout_q <= 1'b0;
      ptr_q     <= 2'd0;
      tcnt_q    <= 8'd0;
    end else begin
      fsm_q     <= fsm_d;
      state_q   <= state_d;
      en_q      <= en_d;
      ack_q     <= ack_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      tcnt_q    <= tcnt_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      StIdle:    if (win_valid) fsm_d = StBusy;
      StBusy:    if (mem_ready || !grant_req || tlast) fsm_d = StRelease;
      StRelease: fsm_d = StIdle;
      default:   fsm_d = StIdle;
    endcase
  end

  // Priority inside BUSY: ready, then request drop, then watchdog.
  always_comb begin
    state_d   = state_q;
    en_d      = 1'b0;
    ack_d     = 4'd0;
    timeout_d = 1'b0;
    ptr_d     = ptr_q;
    tcnt_d    = tcnt_q;
    unique case (fsm_q)
      StIdle: begin
        if (win_valid) begin
          state_d = win_idx;
          en_d    = 1'b1;
          tcnt_d  = 8'd0;
        end
      end
      StBusy: begin
        en_d = 1'b1;
        if (mem_ready) begin
          ack_d = 4'b0001 << state_q;
          en_d  = 1'b0;
          ptr_d = state_q + 2'd1;
        end else if (!grant_req) begin
          en_d  = 1'b0;
          ptr_d = state_q + 2'd1;
        end else if (tlast) begin
          timeout_d = 1'b1;
          en_d      = 1'b0;
          ptr_d     = state_q + 2'd1;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      StRelease: ;
      default: ;
    endcase
  end

  assign state   = state_q;
  assign en      = en_q;
  assign ack0    = ack_q[0];
  assign ack1    = ack_q[1];
  assign ack2    = ack_q[2];
  assign ack3    = ack_q[3];
  assign timeout = timeout_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: controller latency model, scoreboard of expected completions,
// a table of grant vectors and hand-written reset/drop sequences.
module tb_memory_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] rd = 4'd0;
  logic [3:0] wr = 4'd0;
  logic       mem_ready = 1'b0;
  logic [1:0] state;
  logic       en;
  logic       ack0, ack1, ack2, ack3;
  logic       timeout;
  logic [3:0] ack;

  assign ack = {ack3, ack2, ack1, ack0};

  memory_arbiter #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .read0     (rd[0]),
    .read1     (rd[1]),
    .read2     (rd[2]),
    .read3     (rd[3]),
    .write0    (wr[0]),
    .write1    (wr[1]),
    .write2    (wr[2]),
    .write3    (wr[3]),
    .mem_ready (mem_ready),
    .state     (state),
    .en        (en),
    .ack0      (ack0),
    .ack1      (ack1),
    .ack2      (ack2),
    .ack3      (ack3),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] port;
    logic       is_to;
    int         len;
    int         gap;
  } exp_t;

  typedef struct {
    logic [3:0] rd;
    logic [3:0] wr;
    int         lat;
    logic [1:0] port;
    logic       is_to;
    int         len;
    int         gap;
  } vec_t;

  exp_t q[$];
  vec_t vt[13];

  int n_vec = 0;
  int n_err = 0;
  int n_events = 0;
  int exp_ev = 0;
  int lat = 0;
  int busy_cnt = 0;
  int en_len = 0;
  int cyc = 0;
  int last_cyc = 0;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int enc(input logic [3:0] a);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) if (a[i]) r = i;
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] port, input logic is_to, input int len, input int gap);
    exp_t e;
    e.port  = port;
    e.is_to = is_to;
    e.len   = len;
    e.gap   = gap;
    q.push_back(e);
    exp_ev++;
  endtask

  task automatic wait_ev(input int target);
    for (int t = 0; t < 60 && n_events < target; t++) tick();
    chk("wait_event", int'(n_events >= target), 1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: ready after lat cycles of en; monitor scores every ack/timeout pulse.
  always @(negedge clk) begin
    exp_t e;
    if (en) busy_cnt = busy_cnt + 1;
    else busy_cnt = 0;
    mem_ready = (lat != 0) && en && (busy_cnt == lat);

    if (en) begin
      en_len = en_len + 1;
    end else if (ack != 4'd0 || timeout) begin
      n_events = n_events + 1;
      chk("ack_timeout_excl", int'(ack != 4'd0 && timeout), 0);
      chk("ack_onehot", int'($countones(ack) <= 1), 1);
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_pulse: ack=%b timeout=%b, expected none", ack, timeout);
      end else begin
        e = q.pop_front();
        chk("port", timeout ? int'(state) : enc(ack), int'(e.port));
        chk("kind_timeout", int'(timeout), int'(e.is_to));
        chk("en_len", en_len, e.len);
        if (e.gap != 0) chk("gap", cyc - last_cyc, e.gap);
      end
      last_cyc = cyc;
      en_len   = 0;
    end else begin
      en_len = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    vt[0]  = '{4'b1001, 4'b0010, 1, 2'd0, 1'b0, 1, 0};
    vt[1]  = '{4'b1001, 4'b0010, 1, 2'd1, 1'b0, 1, 3};
    vt[2]  = '{4'b1001, 4'b0010, 1, 2'd3, 1'b0, 1, 3};
    vt[3]  = '{4'b1001, 4'b0010, 1, 2'd0, 1'b0, 1, 3};
    vt[4]  = '{4'b1001, 4'b0010, 1, 2'd1, 1'b0, 1, 3};
    vt[5]  = '{4'b1001, 4'b0010, 1, 2'd3, 1'b0, 1, 3};
    vt[6]  = '{4'b0000, 4'b0010, 0, 2'd1, 1'b1, 4, 6};
    vt[7]  = '{4'b1001, 4'b0010, 1, 2'd3, 1'b0, 1, 3};
    vt[8]  = '{4'b1001, 4'b0010, 1, 2'd0, 1'b0, 1, 3};
    vt[9]  = '{4'b1001, 4'b0010, 1, 2'd1, 1'b0, 1, 3};
    vt[10] = '{4'b0100, 4'b0000, 4, 2'd2, 1'b0, 4, 6};
    vt[11] = '{4'b0011, 4'b0010, 2, 2'd0, 1'b0, 2, 4};
    vt[12] = '{4'b0011, 4'b0010, 2, 2'd0, 1'b0, 2, 4};

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_en", int'(en), 0);
    chk("rst_state", int'(state), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_timeout", int'(timeout), 0);

    // Single read on port 2, ready after 3 BUSY cycles; then check pointer moved to 3.
    lat = 3;
    push(2'd2, 1'b0, 3, 0);
    rd = 4'b0100;
    tick();
    chk("grant_en", int'(en), 1);
    chk("grant_state", int'(state), 2);
    wait_ev(exp_ev);
    chk("ack2_high", int'(ack), 4'b0100);
    chk("ack_en_low", int'(en), 0);
    rd = 4'b1100;
    push(2'd3, 1'b0, 3, 0);
    tick();
    chk("release_en_low", int'(en), 0);
    chk("ack2_one_cycle", int'(ack), 0);
    tick();
    chk("regrant_en", int'(en), 1);
    chk("ptr_after_2", int'(state), 3);
    wait_ev(exp_ev);

    for (int i = 0; i < 13; i++) begin
      rd  = vt[i].rd;
      wr  = vt[i].wr;
      lat = vt[i].lat;
      push(vt[i].port, vt[i].is_to, vt[i].len, vt[i].gap);
      wait_ev(exp_ev);
    end

    // Granted port 0 drops its request in the 2nd BUSY cycle.
    rd = 4'd0;
    wr = 4'd0;
    repeat (3) tick();
    lat = 0;
    rd = 4'b0001;
    tick();
    chk("drop_grant_en", int'(en), 1);
    chk("drop_grant_state", int'(state), 0);
    tick();
    chk("drop_busy_en", int'(en), 1);
    rd = 4'd0;
    tick();
    chk("drop_en_low", int'(en), 0);
    chk("drop_no_ack", int'(ack), 0);
    chk("drop_no_timeout", int'(timeout), 0);
    tick();
    chk("drop_release_en", int'(en), 0);
    chk("drop_no_events", n_events, exp_ev);

    // Reset in the middle of a port 3 grant.
    rd = 4'b1000;
    tick();
    chk("pre_rst_en", int'(en), 1);
    chk("pre_rst_state", int'(state), 3);
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_en", int'(en), 0);
    chk("midrst_state", int'(state), 0);
    chk("midrst_ack", int'(ack), 0);
    chk("midrst_timeout", int'(timeout), 0);
    rst = 1'b0;
    lat = 2;
    rd = 4'b1001;
    push(2'd0, 1'b0, 2, 0);
    push(2'd3, 1'b0, 2, 4);
    wait_ev(exp_ev);
    rd = 4'd0;
    repeat (4) tick();
    chk("queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
